unidade_store: RTL and testbench

Store sequencer that moves register-file contents into data memory, the write direction of the existing memory-to-register load path. It accepts store requests (data register, base register, 5-bit offset) through a valid/ready port, buffers them in a small request queue, reads both operands from the register file, and issues one memory write per request at address base[4:0] + offset. It sits between the request source and the `registrador` read ports and `memoria` write port.

---
 rtl/store_pkg.sv | 27 ++
 rtl/fila_req.sv | 65 ++++++
 rtl/unidade_store.sv | 135 +++++++++++++
 tb/tb_unidade_store.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared types for the store sequencer: FSM state encoding, request queue entry
// and the address-sum helper.
package store_pkg;

    localparam int unsigned OFF_W     = 5;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned SUM_W     = 6;

    // FSM state encoding kept as plain constants for older tool flows
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FETCH = 2'd1;
    localparam state_t ST_WRITE = 2'd2;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rs;
        logic [REG_IDX_W-1:0] rbase;
        logic [OFF_W-1:0]     off;
    } req_t;

    // Zero-extended 5+5 bit sum, never wraps (max 62)
    function automatic logic [SUM_W-1:0] sum_addr(input logic [4:0] base,
                                                   input logic [OFF_W-1:0] off);
        return {1'b0, base} + {1'b0, off};
    endfunction

endpackage

// File: rtl/fila_req.sv
// Small synchronous FIFO holding pending store requests. Push while full and pop
// while empty are ignored. QDEPTH must be a power of two so pointers wrap freely.
module fila_req #(
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned WIDTH  = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    logic [WIDTH-1:0] mem_q [QDEPTH];
    logic [WIDTH-1:0] mem_d [QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == (PTR_W+1)'(QDEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Pointer, occupancy and storage next-state
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset; occupancy guards every read
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/unidade_store.sv
// Store sequencer: queues store requests, reads base/data from the register file
// and issues one memory write per request at base[4:0] + off.
// Optional feature: define STORE_STATS_EN to add the 16-bit stores_cnt counter.
module unidade_store
    import store_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned REG_W  = 5,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned QDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [REG_W-1:0]  req_rs,
    input  logic [REG_W-1:0]  req_rbase,
    input  logic [OFF_W-1:0]  req_off,
    output logic [REG_W-1:0]  Ra,
    output logic [REG_W-1:0]  Rb,
    input  logic [DATA_W-1:0] doutA,
    input  logic [DATA_W-1:0] doutB,
    output logic [ADDR_W-1:0] ads,
    output logic              we,
    output logic [DATA_W-1:0] din,
    output logic              busy,
`ifdef STORE_STATS_EN
    output logic [15:0]       stores_cnt,
`endif
    output logic              done
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [REG_W-1:0]  ra_q, ra_d;
    logic [REG_W-1:0]  rb_q, rb_d;
    logic              push, pop;
    logic              q_full, q_empty;
    req_t              push_entry, head;
    logic              unused_dout_hi;

    // Only the low five bits of the base register form the address
    assign unused_dout_hi = ^doutA[DATA_W-1:5];

    assign req_ready  = !q_full;
    assign push       = req_valid && req_ready;
    assign push_entry = '{rs: REG_IDX_W'(req_rs), rbase: REG_IDX_W'(req_rbase), off: req_off};

    fila_req #(
        .QDEPTH (QDEPTH),
        .WIDTH  ($bits(req_t))
    ) u_fila (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .full      (q_full),
        .empty     (q_empty),
        .head      (head)
    );

    // FSM next-state; register-file indices are driven combinationally in FETCH
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Same-cycle push counts so an idle unit fetches on the next cycle
                if (!q_empty || push) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ra_d    = REG_W'(head.rbase);
                rb_d    = REG_W'(head.rs);
                addr_d  = ADDR_W'(sum_addr(doutA[4:0], head.off));
                data_d  = doutB;
                pop     = 1'b1;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = (!q_empty || push) ? ST_FETCH : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign Ra   = ra_d;
    assign Rb   = rb_d;
    assign ads  = addr_q;
    assign din  = data_q;
    // Gated with reset so a write in progress is suppressed at the reset edge
    assign we   = (state_q == ST_WRITE) && rst_n;
    assign done = (state_q == ST_WRITE) && rst_n;
    assign busy = (state_q != ST_IDLE) || !q_empty;

    // Sequencer state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
        end
    end

`ifdef STORE_STATS_EN
    logic [15:0] stats_q, stats_d;

    // Completed-store counter, wraps naturally at 16 bits
    always_comb begin
        stats_d = stats_q + 16'(done);
    end

    // Counter register, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst_n) stats_q <= '0;
        else        stats_q <= stats_d;
    end

    assign stores_cnt = stats_q;
`endif

endmodule

// File: tb/tb_unidade_store.sv
// Self-checking bench for unidade_store: table-driven single stores, a burst that
// fills the queue, and a reset in the middle of a write. Build with
// STORE_STATS_EN defined to also exercise the completed-store counter.
module tb_unidade_store;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_rs, req_rbase, req_off;
    logic [4:0]  Ra, Rb;
    logic [63:0] doutA, doutB;
    logic [5:0]  ads;
    logic        we;
    logic [63:0] din;
    logic        busy;
    logic        done;
`ifdef STORE_STATS_EN
    logic [15:0] stores_cnt;
`endif

    logic [63:0] regs [32];

    always #5 clk = ~clk;

    always_comb begin
        doutA = regs[Ra];
        doutB = regs[Rb];
    end

    unidade_store dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rs     (req_rs),
        .req_rbase  (req_rbase),
        .req_off    (req_off),
        .Ra         (Ra),
        .Rb         (Rb),
        .doutA      (doutA),
        .doutB      (doutB),
        .ads        (ads),
        .we         (we),
        .din        (din),
        .busy       (busy),
`ifdef STORE_STATS_EN
        .stores_cnt (stores_cnt),
`endif
        .done       (done)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int writes_seen = 0;

    typedef struct {
        logic [63:0] ads;
        logic [63:0] din;
        int          exp_cyc;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rbase;
        logic [4:0]  off;
        logic [63:0] a_val;
        logic [63:0] b_val;
        logic [63:0] e_ads;
        logic [63:0] e_din;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every observed write is matched against the oldest expectation
    always @(negedge clk) begin
        sb_t e;
        if (rst_n) begin
            chk("done_eq_we", {63'd0, done}, {63'd0, we});
            if (we) begin
                writes_seen++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_write: got ads=%0d din=%0h want no write", ads, din);
                end else begin
                    e = sb.pop_front();
                    chk("ads", {58'd0, ads}, e.ads);
                    chk("din", din, e.din);
                    if (e.exp_cyc >= 0) chk("write_cycle", cyc, e.exp_cyc);
                end
            end
        end
    end

    task automatic send_one(input logic [4:0] rs, input logic [4:0] rbase, input logic [4:0] off,
                            input logic [63:0] e_ads, input logic [63:0] e_din);
        int n = 0;
        @(posedge clk); #1;
        req_rs = rs; req_rbase = rbase; req_off = off; req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL send_timeout: got ready=0 want ready=1");
        end else begin
            sb.push_back('{ads: e_ads, din: e_din, exp_cyc: cyc + 2});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", {63'd0, (sb.size() == 0) && !busy}, 64'd1);
    endtask

    // Holds req_valid and issues cnt requests (rs=8+i, rbase=16+i, off=i)
    task automatic burst(input int cnt, input logic check_full);
        int c0 = 0;
        int n;
        @(posedge clk); #1;
        req_valid = 1'b1;
        for (int i = 0; i < cnt; i++) begin
            req_rs = 5'(8 + i); req_rbase = 5'(16 + i); req_off = 5'(i);
            @(negedge clk);
            if (i == 0) c0 = cyc;
            if (check_full && i == 5) chk("ready_push_pop_at3", {63'd0, req_ready}, 64'd1);
            if (check_full && i == 7) chk("ready_full_after7", {63'd0, req_ready}, 64'd0);
            n = 0;
            while (!req_ready && n < 20) begin
                n++;
                @(negedge clk);
            end
            if (!req_ready) begin
                total++; bad++;
                $display("FAIL burst_timeout: got ready=0 want ready=1");
            end else begin
                sb.push_back('{ads: 64'(4 * i), din: 64'hB000 + 64'(i), exp_cyc: c0 + 2 + 2 * i});
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        int wb;
        for (int i = 0; i < 32; i++) regs[i] = 64'd0;
        req_valid = 1'b0; req_rs = '0; req_rbase = '0; req_off = '0;
        rst_n = 1'b0;
        vecs[0] = '{5'd3,  5'd10, 5'd5,  64'd16, 64'hDEAD, 64'd21, 64'hDEAD};
        vecs[1] = '{5'd2,  5'd1,  5'd31, 64'd31, 64'h0123_4567_89AB_CDEF, 64'd62,
                    64'h0123_4567_89AB_CDEF};
        vecs[2] = '{5'd2,  5'd1,  5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFEDC_BA98_7654_3210, 64'd62,
                    64'hFEDC_BA98_7654_3210};
        vecs[3] = '{5'd8,  5'd7,  5'd0,  64'hAAAA_0000_0000_0020, 64'h5555_5555_5555_5555, 64'd0,
                    64'h5555_5555_5555_5555};
        vecs[4] = '{5'd4,  5'd4,  5'd10, 64'h1234_5678_9ABC_DEF5, 64'h1234_5678_9ABC_DEF5, 64'd31,
                    64'h1234_5678_9ABC_DEF5};
        vecs[5] = '{5'd31, 5'd0,  5'd19, 64'd12, 64'h8000_0000_0000_0001, 64'd31,
                    64'h8000_0000_0000_0001};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_we",    {63'd0, we},        64'd0);
        chk("rst_busy",  {63'd0, busy},      64'd0);
        chk("rst_done",  {63'd0, done},      64'd0);
        chk("rst_ads",   {58'd0, ads},       64'd0);
        chk("rst_din",   din,                64'd0);
        chk("rst_ra",    {59'd0, Ra},        64'd0);
        chk("rst_rb",    {59'd0, Rb},        64'd0);
`ifdef STORE_STATS_EN
        chk("rst_cnt",   {48'd0, stores_cnt}, 64'd0);
`endif

        // Single stores from idle, each checked for address, data and 2-cycle latency
        for (int v = 0; v < 6; v++) begin
            regs[vecs[v].rbase] = vecs[v].a_val;
            regs[vecs[v].rs]    = vecs[v].b_val;
            send_one(vecs[v].rs, vecs[v].rbase, vecs[v].off, vecs[v].e_ads, vecs[v].e_din);
            drain();
            if (v == 0) begin
                chk("ra_hold", {59'd0, Ra}, 64'd10);
                chk("rb_hold", {59'd0, Rb}, 64'd3);
            end
        end

        // Burst of 8: queue fills, one store per two cycles in request order
        for (int i = 0; i < 8; i++) begin
            regs[16 + i] = 64'(3 * i);
            regs[8 + i]  = 64'hB000 + 64'(i);
        end
        wb = writes_seen;
        burst(8, 1'b1);
        drain();
        chk("burst_writes", writes_seen - wb, 8);

        // Reset while writing request 1 with requests 2 and 3 still queued
        burst(4, 1'b0);
        chk("in_write_before_rst", {63'd0, we}, 64'd1);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rst_gates_we",   {63'd0, we},   64'd0);
        chk("rst_gates_done", {63'd0, done}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("flush_busy",  {63'd0, busy},      64'd0);
        chk("flush_ready", {63'd0, req_ready}, 64'd1);
        wb = writes_seen;
        repeat (10) @(negedge clk);
        chk("flush_no_writes", writes_seen - wb, 0);

`ifdef STORE_STATS_EN
        for (int k = 0; k < 3; k++) begin
            send_one(vecs[0].rs, vecs[0].rbase, vecs[0].off, 64'd21, 64'hDEAD);
            drain();
        end
        chk("cnt_three", {48'd0, stores_cnt}, 64'd3);
        @(negedge clk);
        dut.stats_q = 16'hFFFF;
        send_one(vecs[0].rs, vecs[0].rbase, vecs[0].off, 64'd21, 64'hDEAD);
        drain();
        chk("cnt_wrap", {48'd0, stores_cnt}, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
